uart_receiver_fsm: RTL
======================

Name: uart_receiver_fsm

Overview:
UART receive stage; the downstream partner of the team's UART transmitter FSM, consuming the serial line that block drives. It oversamples rxd at 16x baud, validates the start bit at mid-bit, shifts in 8 data bits LSB first, and checks the stop bit. Received bytes go into a one-entry holding register with a valid/ready handshake. Framing and overrun errors are flagged.

Parameters:
CLOCKSPEED, 50000000, system clock frequency in Hz
BAUDRATE, 9600, line bit rate
OVERSAMPLE, 16, ticks per bit (fixed 16; parameter exists for documentation and tick math)
BAUD_DIV, CLOCKSPEED/(BAUDRATE*OVERSAMPLE), clocks per oversample tick; integer truncation; minimum legal value 1

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
rxd  input  1  asynchronous serial line, idle high
dout  output  8  received byte, valid while dout_valid=1
dout_valid  output  1  holding register full
dout_ready  input  1  consumer accepts dout when dout_valid && dout_ready
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  sticky: byte completed while holding register full; cleared only by rst
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE. dout=0, dout_valid=0, frame_err=0, overrun=0, busy=0. Both synchronizer flops=1. Tick counter, sample counter, bit counter and shift register=0. Reset mid-frame aborts the frame with no output.
- Synchronizer: two flops on rxd. All FSM decisions use rx_s, the second flop.
- Tick generator: counter runs 0..BAUD_DIV-1 and free-runs in every state. tick=1 in the cycle where count==BAUD_DIV-1.
- Sample counter: 4-bit, increments on tick, wraps 15->0. Cleared to 0 on every state entry.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: rx_s==0 -> START at the next edge, independent of tick.
  - START: on tick with sample counter==7 (mid start bit): rx_s==0 -> DATA with bit counter=0; rx_s==1 -> IDLE (glitch rejected, no flags).
  - DATA: on tick with sample counter==15: shift_reg <= {rx_s, shift_reg[7:1]} (LSB first) and bit counter +1. After the 8th sample -> STOP.
  - STOP: on tick with sample counter==15:
    - rx_s==1: byte complete. If dout_valid==0, or dout_valid && dout_ready in the same cycle, then dout<=shift_reg and dout_valid<=1. Otherwise overrun<=1 and the old dout is kept (new byte dropped). Next state IDLE.
    - rx_s==0: frame_err pulses 1 cycle, no load. Next state WAIT_HIGH.
  - WAIT_HIGH: stays until rx_s==1, then IDLE. This prevents break conditions from retriggering.
- Handshake: dout_valid && dout_ready at an edge clears dout_valid, unless a new load occurs in the same cycle (load wins; dout_valid stays 1). dout stays stable while dout_valid=1.
- Bit counter: 3-bit plus terminal detect. Reaching 7 then sampling the final bit transitions to STOP.
- Latency (BAUD_DIV=1): dout_valid rises 2 (sync) + 1 + 8 + 128 + 16 = 155 cycles after the rxd falling edge, tolerance ±1.
- busy=1 from IDLE exit until return to IDLE, WAIT_HIGH included.

Decomposition:
- Shared package (uart_pkg): state encoding constants (IDLE=3'd0, START=3'd1, DATA=3'd2, STOP=3'd3, WAIT_HIGH=3'd4), OVERSAMPLE=16, the BAUD_DIV formula, and the mid-sample index 7 and end-sample index 15. The transmitter uses the same package.
- One natural sub-module: uart_baud_tick. It holds the BAUD_DIV counter and tick output and is reusable by the transmitter. Synchronizer, FSM and holding register stay inline.

Test Plan:
- Loopback byte 8'hA5, BAUD_DIV=1, dout_ready=0 -> dout=8'hA5, dout_valid=1 at 155±1 cycles after start edge; frame_err=0, overrun=0; then dout_ready=1 for 1 cycle -> dout_valid=0.
- rxd low pulse of 4 cycles then high -> FSM returns to IDLE, dout_valid stays 0, no frame_err, busy low again by cycle ~12.
- Byte 8'h3C with stop bit forced 0 and held low 40 cycles -> frame_err single-cycle pulse, dout_valid=0, busy held through WAIT_HIGH, next frame 8'h81 received correctly.
- Two back-to-back bytes 8'h11, 8'h22, dout_ready=0 -> dout=8'h11 retained, overrun=1 at second stop sample. Repeat with dout_ready=1 asserted exactly in the second byte's stop-sample cycle -> dout=8'h22, dout_valid=1, overrun=0.
- rst=1 asserted during DATA bit 4 of byte 8'hF0 -> all outputs 0 next cycle, state IDLE; following byte 8'h0F received correctly.
- Default parameters (BAUD_DIV=325), byte 8'h55 at 5208 clocks/bit -> dout=8'h55. Same byte with transmit bit period ±3% -> still correct.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling constants and
// the baud divider calculation used by both the receiver and transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } uart_state_e;

    localparam int         UART_OVERSAMPLE = 16;
    localparam logic [3:0] MID_SAMPLE      = 4'd7;
    localparam logic [3:0] END_SAMPLE      = 4'd15;

    // Clocks per oversample tick, truncated, never below one.
    function automatic int calc_baud_div(input int clockspeed, input int baudrate, input int oversample);
        int div;
        div = clockspeed / (baudrate * oversample);
        return (div < 1) ? 1 : div;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: free-running divider that pulses tick for one
// clock every BAUD_DIV clocks.
module uart_baud_tick #(
    parameter int BAUD_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int            CW   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] cnt_r;
    logic          tick_s;

    assign tick_s = (cnt_r == LAST);
    assign tick   = tick_s;

    // Divider counter, wraps after the terminal count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (tick_s) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

endmodule

// File: rtl/uart_receiver_fsm.sv
// UART receiver: 16x oversampled 8N1 deserializer with a one-entry holding
// register (valid/ready), framing-error pulse and sticky overrun flag.
module uart_receiver_fsm
    import uart_pkg::*;
#(
    parameter int CLOCKSPEED = 50000000,
    parameter int BAUDRATE   = 9600,
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int BAUD_DIV   = calc_baud_div(CLOCKSPEED, BAUDRATE, OVERSAMPLE)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] dout,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    uart_state_e state_r;
    uart_state_e state_next_s;

    logic       sync1_r;
    logic       rx_sync_r;
    logic       rx_s;
    logic       tick_s;
    logic [3:0] sample_cnt_r;
    logic [2:0] bit_cnt_r;
    logic [7:0] shift_r;

    logic       shift_en_s;
    logic       bit_clr_s;
    logic       byte_done_s;
    logic       frame_err_s;
    logic       load_s;
    logic       ovr_s;

    logic [7:0] dout_r;
    logic       dout_valid_r;
    logic       frame_err_r;
    logic       overrun_r;
    logic       busy_r;

    assign rx_s = rx_sync_r;

    uart_baud_tick #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick_s)
    );

    // Two-flop synchronizer for the asynchronous serial line (idle high).
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r   <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            sync1_r   <= rxd;
            rx_sync_r <= sync1_r;
        end
    end

    // Next-state and per-cycle strobes of the receive FSM.
    always_comb begin
        state_next_s = state_r;
        shift_en_s   = 1'b0;
        bit_clr_s    = 1'b0;
        byte_done_s  = 1'b0;
        frame_err_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_next_s = ST_START;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s && (sample_cnt_r == MID_SAMPLE)) begin
                    if (!rx_s) begin
                        state_next_s = ST_DATA;
                        bit_clr_s    = 1'b1;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    state_next_s = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_s && (sample_cnt_r == END_SAMPLE)) begin
                    shift_en_s = 1'b1;
                    if (bit_cnt_r == 3'd7) begin
                        state_next_s = ST_STOP;
                    end else begin
                        state_next_s = ST_DATA;
                    end
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_STOP: begin
                if (tick_s && (sample_cnt_r == END_SAMPLE)) begin
                    if (rx_s) begin
                        byte_done_s  = 1'b1;
                        state_next_s = ST_IDLE;
                    end else begin
                        frame_err_s  = 1'b1;
                        state_next_s = ST_WAIT_HIGH;
                    end
                end else begin
                    state_next_s = ST_STOP;
                end
            end
            ST_WAIT_HIGH: begin
                if (rx_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WAIT_HIGH;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // A completed byte is accepted when the holding register is empty or is
    // being emptied in the same cycle; otherwise it is dropped as an overrun.
    always_comb begin
        load_s = 1'b0;
        ovr_s  = 1'b0;
        if (byte_done_s) begin
            load_s = !dout_valid_r || dout_ready;
            ovr_s  = dout_valid_r && !dout_ready;
        end else begin
            load_s = 1'b0;
            ovr_s  = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Oversample position within the current bit; restarts on every state entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_cnt_r <= 4'd0;
        end else if (state_next_s != state_r) begin
            sample_cnt_r <= 4'd0;
        end else if (tick_s) begin
            sample_cnt_r <= sample_cnt_r + 4'd1;
        end else begin
            sample_cnt_r <= sample_cnt_r;
        end
    end

    // Data bit index, cleared at the validated start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_r <= 3'd0;
        end else if (bit_clr_s) begin
            bit_cnt_r <= 3'd0;
        end else if (shift_en_s) begin
            bit_cnt_r <= bit_cnt_r + 3'd1;
        end else begin
            bit_cnt_r <= bit_cnt_r;
        end
    end

    // Shift register, LSB arrives first so new bits enter at the top.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_r <= 8'd0;
        end else if (shift_en_s) begin
            shift_r <= {rx_s, shift_r[7:1]};
        end else begin
            shift_r <= shift_r;
        end
    end

    // Holding register, handshake, error flags and busy indication.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_r       <= 8'd0;
            dout_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            overrun_r    <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            frame_err_r <= frame_err_s;
            busy_r      <= (state_next_s != ST_IDLE);
            if (ovr_s) begin
                overrun_r <= 1'b1;
            end else begin
                overrun_r <= overrun_r;
            end
            if (load_s) begin
                dout_r       <= shift_r;
                dout_valid_r <= 1'b1;
            end else if (dout_valid_r && dout_ready) begin
                dout_r       <= dout_r;
                dout_valid_r <= 1'b0;
            end else begin
                dout_r       <= dout_r;
                dout_valid_r <= dout_valid_r;
            end
        end
    end

    assign dout       = dout_r;
    assign dout_valid = dout_valid_r;
    assign frame_err  = frame_err_r;
    assign overrun    = overrun_r;
    assign busy       = busy_r;

endmodule
